// File: rtl/key_onehot_capture.sv
// Eight-key capture front end: two-flop synchroniser, per-key debounce, press
// detection and lowest-index priority into a registered one-hot vector.
module key_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys_in,
  input  logic       clear,
  output logic [7:0] onehot,
  output logic       press_valid,
  output logic [7:0] keys_held
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       deb;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       rise;
  logic [7:0]       winner;

  // rise marks a key whose debounced level flips 0->1 on this edge; the
  // two's-complement trick keeps only the lowest set bit.
  always_comb begin
    rise   = '0;
    winner = '0;
    for (int i = 0; i < 8; i++) begin
      rise[i] = sync2[i] & ~deb[i] & (cnt[i] == CNT_MAX);
    end
    winner = rise & (~rise + 8'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= keys_in;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // press_valid is a one-cycle strobe with no ready: it qualifies onehot in
  // exactly the cycle a new capture first appears. A press beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      onehot      <= '0;
      press_valid <= 1'b0;
    end else if (|rise) begin
      onehot      <= winner;
      press_valid <= 1'b1;
    end else if (clear) begin
      onehot      <= '0;
      press_valid <= 1'b0;
    end else begin
      press_valid <= 1'b0;
    end
  end

  assign keys_held = deb;

endmodule
